uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 14 +
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial receive port bundle: the line input plus the received-word outputs.
// master = line driver / word consumer, slave = the receiver itself.
interface uart_rx_if #(
    parameter int DATA_SIZE = 8
);
    logic                 rx;
    logic [DATA_SIZE-1:0] data;
    logic                 valid;
    logic                 frame_err;
    logic                 busy;

    modport master (output rx, input data, valid, frame_err, busy);
    modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, start-bit qualification at half a bit,
// mid-bit sampling of DATA_SIZE LSB-first bits, stop-bit check with break hold-off.
module uart_rx #(
    parameter int unsigned FREQ      = 1_000_000_000,
    parameter int unsigned BAUD      = 115200,
    parameter int          DATA_SIZE = 8
) (
    input  logic        clk,
    input  logic        reset,
    uart_rx_if.slave    bus
);
    localparam int unsigned DIVISOR = FREQ / BAUD;
    localparam int unsigned HALF    = DIVISOR / 2;
    localparam int          CW      = $clog2(DIVISOR);
    localparam int          IW      = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

    if (DIVISOR < 4) begin : g_bad_divisor
        $error("uart_rx: FREQ/BAUD must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_SIZE-1:0] shreg, shreg_n;
    logic [DATA_SIZE-1:0] data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 ferr_q, ferr_n;
    logic                 rx_m, rx_s;
    logic [DATA_SIZE:0]   shin;

    // New bit enters at the MSB so the first-received bit ends up in bit 0.
    assign shin = {rx_s, shreg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ferr_q  <= ferr_n;
            rx_m    <= bus.rx;
            rx_s    <= rx_m;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CW'(DIVISOR - 1)) begin
                    cnt_n   = '0;
                    shreg_n = shin[DATA_SIZE:1];
                    idx_n   = idx + IW'(1);
                    if (idx == IW'(DATA_SIZE - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == CW'(DIVISOR - 1)) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line is a break, not a new start bit.
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level line model predicts each pulse,
// its word and its cycle; one negedge process checks every cycle.
module tb_uart_rx;
    localparam int FREQ = 1600;
    localparam int BAUD = 100;
    localparam int DS   = 8;
    localparam int DIV  = FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int LAT  = 2 + HALF + (DS + 1) * DIV;

    typedef struct {
        bit          ferr;
        logic [DS-1:0] d;
        int          at;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   en = 1'b0;

    ev_t           exq[$];
    logic [DS-1:0] mdata = '0;
    int            n_valid = 0, n_ferr = 0;
    int            last_valid = 0, prev_valid = 0, last_fall = 0;

    uart_rx_if #(.DATA_SIZE(DS)) bus ();

    uart_rx #(.FREQ(FREQ), .BAUD(BAUD), .DATA_SIZE(DS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: every meaningful cycle checked against the frame model.
    always @(negedge clk) begin
        ev_t e;
        if (!reset) begin
            chk("reset_outputs", {bus.data, bus.valid, bus.frame_err, bus.busy}, 32'h0);
        end else if (en) begin
            chk("pulse_exclusive", {31'b0, bus.valid & bus.frame_err}, 32'h0);
            if (bus.valid || bus.frame_err) begin
                if (bus.valid) begin
                    n_valid++;
                    prev_valid = last_valid;
                    last_valid = cyc;
                end else begin
                    n_ferr++;
                end
                if (exq.size() == 0) begin
                    chk("spurious_pulse", {30'b0, bus.valid, bus.frame_err}, 32'h0);
                end else begin
                    e = exq.pop_front();
                    chk("pulse_kind", {31'b0, bus.frame_err}, {31'b0, e.ferr});
                    chk("pulse_cycle_in_window",
                        {31'b0, (cyc >= e.at - 1) && (cyc <= e.at + 1)}, 32'h1);
                    if (bus.valid) mdata = e.d;
                end
            end else if (exq.size() > 0 && cyc > exq[0].at + 1) begin
                e = exq.pop_front();
                chk("missing_pulse_at", cyc, e.at);
            end
            chk("data_value", {24'b0, bus.data}, {24'b0, mdata});
        end
    end

    // One bit period; optional noise in the first two cycles, far from mid-bit.
    task automatic drive_bit(input logic v, input bit noise);
        #1 bus.rx = v ^ (noise & 1'($urandom_range(0, 1)));
        repeat (2) @(posedge clk);
        #1 bus.rx = v;
        repeat (DIV - 2) @(posedge clk);
    endtask

    // Called at a posedge; returns at a posedge at the end of the frame.
    task automatic send(input logic [DS-1:0] d, input bit stop, input int hold,
                        input bit noise, input int abort);
        ev_t e;
        #1 bus.rx = 1'b0;
        last_fall = cyc + 1;
        e.ferr = !stop;
        e.d    = d;
        e.at   = cyc + 1 + LAT;
        exq.push_back(e);
        repeat (DIV) @(posedge clk);
        for (int i = 0; i < DS; i++) begin
            if (i == abort) begin
                #1 bus.rx = d[i];
                repeat (5) @(posedge clk);
                #1 reset = 1'b0;
                exq.delete();
                mdata = '0;
                bus.rx = 1'b1;
                repeat (3) @(posedge clk);
                #1 reset = 1'b1;
                repeat (DIV) @(posedge clk);
                return;
            end
            drive_bit(d[i], noise);
        end
        drive_bit(stop, noise);
        if (!stop) begin
            repeat (hold) @(posedge clk);
            @(negedge clk) chk("break_busy", {31'b0, bus.busy}, 32'h1);
            @(posedge clk);
            #1 bus.rx = 1'b1;
            repeat (DIV) @(posedge clk);
        end
    endtask

    task automatic glitch(input int n);
        #1 bus.rx = 1'b0;
        repeat (n) @(posedge clk);
        #1 bus.rx = 1'b1;
        repeat (2 * DIV) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, gap, r;
        logic [DS-1:0] d;
        bit st;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_data", {24'b0, bus.data}, 32'h0);
        chk("reset_busy", {31'b0, bus.busy}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        en = 1'b1;
        repeat (5) @(posedge clk);

        v0 = n_valid; f0 = n_ferr;
        send(8'hA5, 1'b1, 0, 1'b0, -1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("a5_valid_count", n_valid - v0, 1);
        chk("a5_data", {24'b0, bus.data}, 32'hA5);
        chk("a5_no_ferr", n_ferr - f0, 0);
        chk("a5_busy_after", {31'b0, bus.busy}, 32'h0);

        v0 = n_valid; f0 = n_ferr;
        @(posedge clk);
        glitch(4);
        @(negedge clk);
        chk("glitch_no_pulse", (n_valid - v0) + (n_ferr - f0), 0);
        chk("glitch_data", {24'b0, bus.data}, 32'hA5);
        chk("glitch_busy", {31'b0, bus.busy}, 32'h0);

        v0 = n_valid; f0 = n_ferr;
        @(posedge clk);
        send(8'h3C, 1'b0, 40, 1'b0, -1);
        @(negedge clk);
        chk("ferr_count", n_ferr - f0, 1);
        chk("ferr_no_valid", n_valid - v0, 0);
        chk("ferr_data_kept", {24'b0, bus.data}, 32'hA5);
        chk("ferr_busy_released", {31'b0, bus.busy}, 32'h0);

        v0 = n_valid;
        @(posedge clk);
        send(8'h00, 1'b1, 0, 1'b0, -1);
        send(8'hFF, 1'b1, 0, 1'b0, -1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("b2b_count", n_valid - v0, 2);
        chk("b2b_spacing", last_valid - prev_valid, 160);
        chk("b2b_data", {24'b0, bus.data}, 32'hFF);

        v0 = n_valid; f0 = n_ferr;
        @(posedge clk);
        send(8'h5A, 1'b1, 0, 1'b0, 4);
        send(8'h81, 1'b1, 0, 1'b0, -1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("abort_count", n_valid - v0, 1);
        chk("abort_no_ferr", n_ferr - f0, 0);
        chk("after_abort_data", {24'b0, bus.data}, 32'h81);

        @(posedge clk);
        send(8'h01, 1'b1, 0, 1'b0, -1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("latency_01", {31'b0, (last_valid - last_fall >= 153) &&
                                  (last_valid - last_fall <= 155)}, 32'h1);
        chk("latency_01_data", {24'b0, bus.data}, 32'h01);

        @(posedge clk);
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                glitch($urandom_range(1, 5));
            end else begin
                d  = DS'($urandom);
                st = (r != 2);
                send(d, st, st ? 0 : $urandom_range(0, 30), 1'($urandom_range(0, 1)), -1);
                gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 20);
                repeat (gap) @(posedge clk);
            end
        end

        repeat (LAT + 2 * DIV) @(posedge clk);
        @(negedge clk);
        chk("events_drained", exq.size(), 0);
        chk("idle_at_end", {31'b0, bus.busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
